ifid_decode_stage: RTL and testbench

Instruction-fetch/decode boundary stage sitting directly downstream of the instruction memory unit. Accepts each 32-bit instruction word and its PC over a valid/ready handshake and splits it into opcode and operand fields. Buffers decoded entries in a small FIFO so fetch can run ahead of a stalled decode/execute stage. Presents one decoded instruction at a time to the register-file/execute side.

---
 rtl/ifid_decode_stage.sv | 131 +++++++++++++
 tb/tb_ifid_decode_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifid_decode_stage.sv
// IF/ID boundary stage: decodes each accepted instruction word and buffers it in a small FIFO.
// Optional macro IFID_ILLEGAL_TRAP_EN drops illegal opcodes at write time and pulses illegal_op_o.
module ifid_decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [PC_W-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] out_pc_o,
  output logic [5:0]      out_opcode_o,
  output logic [4:0]      out_rs_o,
  output logic [4:0]      out_rt_o,
  output logic [4:0]      out_rd_o,
  output logic [4:0]      out_shamt_o,
  output logic [31:0]     out_imm_o,
  output logic [25:0]     out_target_o,
  output logic [1:0]      out_class_o,
  output logic            illegal_op_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [31:0]     imm;
    logic [25:0]     target;
    logic [1:0]      cls;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           dec;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, wr_en;

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc_i;
    dec.opcode = in_instr_i[31:26];
    dec.rs     = in_instr_i[25:21];
    dec.rt     = in_instr_i[20:16];
    dec.rd     = in_instr_i[15:11];
    dec.shamt  = in_instr_i[10:6];
    dec.target = in_instr_i[25:0];
    if (dec.opcode <= 6'h14)      dec.cls = 2'b00;
    else if (dec.opcode <= 6'h20) dec.cls = 2'b01;
    else if (dec.opcode <= 6'h27) dec.cls = 2'b10;
    else                          dec.cls = 2'b11;
    // lui shifts up, logical immediates zero-extend, everything else sign-extends
    if (dec.opcode == 6'h15)
      dec.imm = {in_instr_i[15:0], 16'h0000};
    else if (dec.opcode >= 6'h19 && dec.opcode <= 6'h1B)
      dec.imm = {16'h0000, in_instr_i[15:0]};
    else
      dec.imm = {{16{in_instr_i[15]}}, in_instr_i[15:0]};
  end

  assign in_ready_o  = (count_q != FULL_CNT) && !rst;
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

`ifdef IFID_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign wr_en        = push && (dec.cls != 2'b11);
  assign illegal_op_o = illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= push && (dec.cls == 2'b11);
  end
`else
  assign wr_en        = push;
  assign illegal_op_o = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) begin
          mem_q[wr_ptr_q] <= dec;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_pc_o     = head.pc;
  assign out_opcode_o = head.opcode;
  assign out_rs_o     = head.rs;
  assign out_rt_o     = head.rt;
  assign out_rd_o     = head.rd;
  assign out_shamt_o  = head.shamt;
  assign out_imm_o    = head.imm;
  assign out_target_o = head.target;
  assign out_class_o  = head.cls;
endmodule

// File: tb/tb_ifid_decode_stage.sv
// Directed bench for ifid_decode_stage: decode vector table plus backpressure, flush, illegal and reset sequences.
module tb_ifid_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [31:0] in_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_pc_o;
  logic [5:0]  out_opcode_o;
  logic [4:0]  out_rs_o, out_rt_o, out_rd_o, out_shamt_o;
  logic [31:0] out_imm_o;
  logic [25:0] out_target_o;
  logic [1:0]  out_class_o;
  logic        illegal_op_o;

  int checks = 0;
  int errors = 0;

  ifid_decode_stage #(.PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_opcode_o(out_opcode_o),
    .out_rs_o(out_rs_o), .out_rt_o(out_rt_o), .out_rd_o(out_rd_o),
    .out_shamt_o(out_shamt_o), .out_imm_o(out_imm_o),
    .out_target_o(out_target_o), .out_class_o(out_class_o),
    .illegal_op_o(illegal_op_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] imm;
    logic [25:0] tgt;
    logic [1:0]  cls;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid_i = 1'b1;
    in_instr_i = instr;
    in_pc_i    = pc;
  endtask

  initial begin
    //              instr         pc        op     rs  rt  rd  sh  imm           tgt           cls
    vecs[0] = '{32'h0885_1800, 32'h8,   6'h02, 4,  5,  3,  0,  32'h0000_1800, 26'h085_1800, 2'b00};
    vecs[1] = '{32'h5822_FFF0, 32'h10,  6'h16, 1,  2,  31, 31, 32'hFFFF_FFF0, 26'h022_FFF0, 2'b01};
    vecs[2] = '{32'h6800_FFF0, 32'h14,  6'h1A, 0,  0,  31, 31, 32'h0000_FFF0, 26'h000_FFF0, 2'b01};
    vecs[3] = '{32'h5403_1234, 32'h18,  6'h15, 0,  3,  2,  8,  32'h1234_0000, 26'h003_1234, 2'b01};
    vecs[4] = '{32'h8400_ABCD, 32'h1C,  6'h21, 0,  0,  21, 15, 32'hFFFF_ABCD, 26'h000_ABCD, 2'b10};
    vecs[5] = '{32'h5000_0000, 32'h20,  6'h14, 0,  0,  0,  0,  32'h0000_0000, 26'h000_0000, 2'b00};
    vecs[6] = '{32'h8000_8000, 32'h24,  6'h20, 0,  0,  16, 0,  32'hFFFF_8000, 26'h000_8000, 2'b01};
    vecs[7] = '{32'h6C00_8001, 32'h28,  6'h1B, 0,  0,  16, 0,  32'h0000_8001, 26'h000_8001, 2'b01};
    vecs[8] = '{32'h6000_FFFF, 32'h2C,  6'h18, 0,  0,  31, 31, 32'hFFFF_FFFF, 26'h000_FFFF, 2'b01};

    #12;
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready_o, 1);

    // Decode table: each word pushed into an empty buffer with out_ready high
    for (int i = 0; i < 9; i++) begin
      push_word(vecs[i].instr, vecs[i].pc);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid_o, 1);
      chk($sformatf("v%0d_pc", i), out_pc_o, vecs[i].pc);
      chk($sformatf("v%0d_op", i), out_opcode_o, vecs[i].op);
      chk($sformatf("v%0d_rs", i), out_rs_o, vecs[i].rs);
      chk($sformatf("v%0d_rt", i), out_rt_o, vecs[i].rt);
      chk($sformatf("v%0d_rd", i), out_rd_o, vecs[i].rd);
      chk($sformatf("v%0d_sh", i), out_shamt_o, vecs[i].sh);
      chk($sformatf("v%0d_imm", i), out_imm_o, vecs[i].imm);
      chk($sformatf("v%0d_tgt", i), out_target_o, vecs[i].tgt);
      chk($sformatf("v%0d_cls", i), out_class_o, vecs[i].cls);
      chk($sformatf("v%0d_ill", i), illegal_op_o, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_drained", i), out_valid_o, 0);
    end

    // Backpressure: three words, only two fit
    out_ready_i = 1'b0;
    push_word(32'h0000_0001, 32'h100);
    chk("bp_rdy0", in_ready_o, 1);
    push_word(32'h0000_0002, 32'h104);
    chk("bp_rdy1", in_ready_o, 1);
    push_word(32'h0000_0003, 32'h108);
    chk("bp_full_rdy", in_ready_o, 0);
    chk("bp_head_a", out_pc_o, 32'h100);
    @(negedge clk);
    chk("bp_still_full", in_ready_o, 0);
    chk("bp_stable_pc", out_pc_o, 32'h100);
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_head_b", out_pc_o, 32'h104);
    chk("bp_rdy_after_pop", in_ready_o, 1);
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("bp_head_c_valid", out_valid_o, 1);
    chk("bp_head_c", out_pc_o, 32'h108);
    chk("bp_head_c_imm", out_imm_o, 32'h3);
    @(negedge clk);
    chk("bp_empty", out_valid_o, 0);

    // Flush of a full buffer while a word is offered
    out_ready_i = 1'b0;
    push_word(32'h0000_0011, 32'h180);
    push_word(32'h0000_0012, 32'h184);
    @(negedge clk);
    chk("fl_full", in_ready_o, 0);
    flush_i    = 1'b1;
    in_instr_i = 32'h0000_0013;
    in_pc_i    = 32'h200;
    @(negedge clk);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("fl_out_valid", out_valid_o, 0);
    chk("fl_in_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("fl_stays_empty", out_valid_o, 0);
    push_word(32'h0000_0014, 32'h300);
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("fl_next_pc", out_pc_o, 32'h300);
    @(negedge clk);
    chk("fl_next_drained", out_valid_o, 0);

    // Illegal opcode 0x3F
    push_word(32'hFC00_0000, 32'h400);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
`ifdef IFID_ILLEGAL_TRAP_EN
    chk("ill_pulse", illegal_op_o, 1);
    chk("ill_not_buffered", out_valid_o, 0);
    @(posedge clk); #1;
    chk("ill_pulse_end", illegal_op_o, 0);
`else
    chk("ill_valid", out_valid_o, 1);
    chk("ill_class", out_class_o, 2'b11);
    chk("ill_opcode", out_opcode_o, 6'h3F);
    chk("ill_no_pulse", illegal_op_o, 0);
    @(posedge clk); #1;
    chk("ill_drained", out_valid_o, 0);
`endif

    // Async reset with two entries held
    out_ready_i = 1'b0;
    push_word(32'h0000_0021, 32'h500);
    push_word(32'h0000_0022, 32'h504);
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("ar_full", out_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid_o, 0);
    chk("ar_out_pc", out_pc_o, 0);
    chk("ar_out_imm", out_imm_o, 0);
    chk("ar_in_ready", in_ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_rel_in_ready", in_ready_o, 1);
    chk("ar_rel_out_valid", out_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
